arith_reduce_addi: RTL and testbench

Streaming integer sum-reduction stage placed directly downstream of the integer multiplier in dot-product and MAC datapaths. It accepts a reduction length on a control channel, then sums exactly that many elements from the data channel, wrapping modulo 2^WIDTH. It emits the sum on a valid/ready result channel, which closes the multiply-then-reduce pair. All channels use the same valid/ready/data handshake as the arithmetic operator library.

---
 rtl/arith_reduce_addi.sv | 140 ++++++++++++++
 tb/tb_arith_reduce_addi.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_reduce_addi.sv
// ---------------------------------------------------------------------------
// arith_reduce_addi
//
// Streaming integer sum-reduction stage. It sits directly after the integer
// multiplier in dot-product and MAC datapaths. A reduction length N is
// accepted on the len channel. Exactly N elements are then summed from the
// in channel, modulo 2^WIDTH. The sum is presented on the result channel.
// All three channels use a valid/ready handshake. A transfer happens when
// valid and ready are both high at a rising clock edge.
//
// Parameters:
//   WIDTH        element and result width
//   CNT_W        width of the reduction-length field (max N = 2^CNT_W-1)
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   len_valid    reduction length offered
//   len_ready    reduction length accepted
//   len_data     number of elements N in the next reduction
//   in_valid     element offered
//   in_ready     element accepted
//   in_data      element value
//   result_valid sum available
//   result_ready downstream accepts the sum
//   result_data  sum of the N accepted elements, mod 2^WIDTH
// ---------------------------------------------------------------------------
module arith_reduce_addi #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             len_valid,
  output logic             len_ready,
  input  logic [CNT_W-1:0] len_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result_data
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [CNT_W-1:0] remaining, remaining_next;

  logic len_fire;
  logic in_fire;

  // Handshake outputs come only from registered state, plus rst.
  // In EMIT, len_ready also follows result_ready.
  // When the result is taken, the next length can load in the same cycle,
  // so the len channel sees no bubble between reductions.
  // While rst is high, every ready/valid is held low so that nothing
  // transfers during reset.
  always_comb begin
    len_ready    = 1'b0;
    in_ready     = 1'b0;
    result_valid = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE:    len_ready    = 1'b1;
        ACCUM:   in_ready     = 1'b1;
        EMIT: begin
          result_valid = 1'b1;
          len_ready    = result_ready;
        end
        default: ;
      endcase
    end
  end

  assign len_fire    = len_valid & len_ready;
  assign in_fire     = in_valid & in_ready;
  assign result_data = acc;

  // Next-state logic.
  // A length of zero goes straight to EMIT with a zero sum.
  // This guarantees ACCUM is never entered with remaining == 0,
  // so the down-counter cannot underflow.
  // In EMIT, the sum is accepted in the same cycle as any following length.
  always_comb begin
    state_next     = state;
    acc_next       = acc;
    remaining_next = remaining;
    unique case (state)
      IDLE: begin
        if (len_fire) begin
          acc_next       = '0;
          remaining_next = len_data;
          state_next     = (len_data == '0) ? EMIT : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire) begin
          acc_next       = acc + in_data;
          remaining_next = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state_next = EMIT;
          end
        end
      end
      EMIT: begin
        if (result_ready) begin
          if (len_fire) begin
            acc_next       = '0;
            remaining_next = len_data;
            state_next     = (len_data == '0) ? EMIT : ACCUM;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  // Reset drops any partial sum and any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      remaining <= remaining_next;
    end
  end

endmodule

// File: tb/tb_arith_reduce_addi.sv
// ---------------------------------------------------------------------------
// tb_arith_reduce_addi
//
// Self-checking bench for arith_reduce_addi, with WIDTH=8 so that modular
// wrap is easy to exercise. Stimulus tasks push each expected sum onto a
// scoreboard queue. A separate monitor pops that queue and compares it on
// every result handshake.
// ---------------------------------------------------------------------------
module tb_arith_reduce_addi;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             len_valid;
  logic             len_ready;
  logic [CNT_W-1:0] len_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] result_data;

  logic [WIDTH-1:0] sb[$];
  int total  = 0;
  int bad    = 0;
  int in_hs  = 0;
  int start_hs;

  arith_reduce_addi #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .len_valid    (len_valid),
    .len_ready    (len_ready),
    .len_data     (len_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // One comparison. A mismatch produces a single FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor. It samples on the falling edge, midway between active edges.
  // It counts element handshakes, and it checks each sum that is about to
  // be taken against the scoreboard.
  always @(negedge clk) begin
    if (in_valid && in_ready) in_hs++;
    if (result_valid && result_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_result", {31'b0, result_valid}, 32'd0);
      end else begin
        checkOutput("result_data", {24'b0, result_data}, {24'b0, sb.pop_front()});
      end
    end
  end

  // Offer a length and hold it until it is accepted.
  // The caller must be just after a rising edge.
  task automatic sendLen(input logic [CNT_W-1:0] n);
    int   cyc = 0;
    logic seen;
    len_valid = 1'b1;
    len_data  = n;
    do begin
      @(negedge clk);
      seen = len_ready;
      @(posedge clk);
      cyc++;
    end while (!seen && cyc < 50);
    #1 len_valid = 1'b0;
    if (!seen) checkOutput("len_timeout", {31'b0, len_ready}, 32'd1);
  endtask

  // Offer one element, optionally after some idle cycles, and hold it
  // until it is accepted.
  task automatic sendElem(input logic [WIDTH-1:0] v, input int gap);
    int   cyc = 0;
    logic seen;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    in_valid = 1'b1;
    in_data  = v;
    do begin
      @(negedge clk);
      seen = in_ready;
      @(posedge clk);
      cyc++;
    end while (!seen && cyc < 50);
    #1 in_valid = 1'b0;
    if (!seen) checkOutput("in_timeout", {31'b0, in_ready}, 32'd1);
  endtask

  // Issue one full reduction and record its hand-computed sum.
  // Element i is taken from vals[i*WIDTH +: WIDTH].
  task automatic applyStimulus(input int n, input logic [63:0] vals,
                               input logic [WIDTH-1:0] expected, input int max_gap);
    sb.push_back(expected);
    sendLen(CNT_W'(n));
    for (int i = 0; i < n; i++) begin
      sendElem(vals[i*WIDTH +: WIDTH], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  // Wait, with a bound, until every expected sum has been observed.
  task automatic waitDrain();
    int c = 0;
    while (sb.size() != 0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    len_valid    = 1'b0;
    len_data     = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    result_ready = 1'b1;

    // Reset: all handshakes are forced low, then the IDLE outputs appear.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_len_ready", {31'b0, len_ready}, 32'd0);
    checkOutput("rst_result_valid", {31'b0, result_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_len_ready", {31'b0, len_ready}, 32'd1);
    checkOutput("post_rst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("post_rst_result_valid", {31'b0, result_valid}, 32'd0);
    checkOutput("post_rst_result_data", {24'b0, result_data}, 32'd0);
    @(posedge clk);
    #1;

    // Basic: 1+2+3+4 = 10. The result is valid the cycle after the 4th element.
    start_hs = in_hs;
    applyStimulus(4, 64'h04030201, 8'd10, 0);
    @(negedge clk);
    checkOutput("basic_latency", {31'b0, result_valid}, 32'd1);
    waitDrain();
    checkOutput("basic_in_count", in_hs - start_hs, 32'd4);

    // Wrap: 0xF0+0x20 = 0x110 -> 0x10, and 3*0xFF = 0x2FD -> 0xFD.
    applyStimulus(2, 64'h20F0, 8'h10, 0);
    waitDrain();
    applyStimulus(3, 64'hFFFFFF, 8'hFD, 0);
    waitDrain();

    // Zero length: a zero sum is valid the next cycle, and no element is taken.
    start_hs = in_hs;
    sb.push_back(8'd0);
    sendLen('0);
    @(negedge clk);
    checkOutput("zero_result_valid", {31'b0, result_valid}, 32'd1);
    checkOutput("zero_result_data", {24'b0, result_data}, 32'd0);
    checkOutput("zero_in_ready", {31'b0, in_ready}, 32'd0);
    waitDrain();
    checkOutput("zero_in_count", in_hs - start_hs, 32'd0);

    // Backpressure: 3+4+5 = 12 with random gaps, then a 5-cycle stall in EMIT.
    // A stray element offered during the stall must not be consumed.
    start_hs     = in_hs;
    result_ready = 1'b0;
    applyStimulus(3, 64'h050403, 8'd12, 2);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_result_valid", {31'b0, result_valid}, 32'd1);
      checkOutput("stall_result_data", {24'b0, result_data}, 32'd12);
      checkOutput("stall_len_ready", {31'b0, len_ready}, 32'd0);
      checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid     = 1'b0;
    result_ready = 1'b1;
    waitDrain();
    checkOutput("stall_in_count", in_hs - start_hs, 32'd3);

    // Back-to-back: {5,6} -> 11, then {7} -> 7.
    // The second length loads in EMIT, in the same cycle the result is taken.
    sb.push_back(8'd11);
    sb.push_back(8'd7);
    sendLen(16'd2);
    sendElem(8'd5, 0);
    sendElem(8'd6, 0);
    len_valid = 1'b1;
    len_data  = 16'd1;
    @(negedge clk);
    checkOutput("b2b_result_valid", {31'b0, result_valid}, 32'd1);
    checkOutput("b2b_len_ready", {31'b0, len_ready}, 32'd1);
    @(posedge clk);
    #1 len_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    sendElem(8'd7, 0);
    waitDrain();

    // Reset in the middle of a reduction: no result may appear afterwards.
    sendLen(16'd5);
    sendElem(8'd1, 0);
    sendElem(8'd2, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_len_ready", {31'b0, len_ready}, 32'd0);
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("midrst_result_valid", {31'b0, result_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("after_rst_len_ready", {31'b0, len_ready}, 32'd1);
    checkOutput("after_rst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("after_rst_result_valid", {31'b0, result_valid}, 32'd0);
    checkOutput("after_rst_result_data", {24'b0, result_data}, 32'd0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    applyStimulus(1, 64'h09, 8'd9, 0);
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
